// File: rtl/noc_pkg.sv
// Shared NoC router types: flit type encoding, flit layout and the output-stage FSM states.
// Pure declarations; no latency and no backpressure.
package noc_pkg;

  localparam int DATA_W = 32;
  localparam int FLIT_W = 2 + DATA_W;

  typedef enum logic [1:0] {
    FT_BODY     = 2'b00,
    FT_HEAD     = 2'b01,
    FT_TAIL     = 2'b10,
    FT_HEADTAIL = 2'b11
  } flit_type_t;

  typedef struct packed {
    flit_type_t             ftype;
    logic [DATA_W-1:0]      data;
  } flit_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first request at or after ptr, wrapping; next ptr is winner+1.
// Purely combinational; en=0 forces an empty grant and leaves ptr unchanged.
module rr_arbiter #(
  parameter int PORT_N = 5,
  parameter int PTR_W  = 3
) (
  input  logic [PORT_N-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  input  logic              en,
  output logic [PORT_N-1:0] grant,
  output logic [PTR_W-1:0]  next_ptr
);

  int   idx;
  logic found;

  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < PORT_N; i++) begin
      idx = (int'(ptr) + i) % PORT_N;
      if (en && !found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        next_ptr    = PTR_W'((idx + 1) % PORT_N);
      end
    end
  end

endmodule

// File: rtl/outputc_arb.sv
// Router output channel: round-robin wormhole arbitration, credit tracking, one registered flit out
// (1-cycle latency); no grant while credit is zero. OUTPUTC_STATS_EN adds flit/stall counters.
module outputc_arb
  import noc_pkg::*;
#(
  parameter int PORT_N    = 5,
  parameter int DATA_W    = 32,
  parameter int BUF_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PORT_N-1:0]            req_i,
  input  logic [PORT_N*(2+DATA_W)-1:0] flit_i,
  output logic [PORT_N-1:0]            grant_o,
  output logic [1+DATA_W:0]            flit_o,
  output logic                         valid_o,
  input  logic                         credit_i,
  output logic                         busy_o,
  output logic                         cred_err_o
`ifdef OUTPUTC_STATS_EN
  ,
  output logic [31:0]                  flit_cnt_o,
  output logic [31:0]                  stall_cnt_o
`endif
);

  localparam int FW    = 2 + DATA_W;
  localparam int PTR_W = (PORT_N > 1) ? $clog2(PORT_N) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  arb_state_t        state, state_nxt;
  logic [PTR_W-1:0]  ptr, ptr_nxt, owner, owner_nxt, arb_ptr, win_idx;
  logic [CNT_W-1:0]  credit, credit_nxt;
  logic [PORT_N-1:0] arb_grant;
  logic              arb_en, has_credit, granted, cred_full;
  logic [FW-1:0]     sel_flit;
  flit_type_t        sel_type;

  assign has_credit = (credit != '0);
  assign cred_full  = (credit == CNT_W'(BUF_DEPTH));
  assign arb_en     = (state == ST_IDLE) && has_credit;

  rr_arbiter #(
    .PORT_N (PORT_N),
    .PTR_W  (PTR_W)
  ) u_rr (
    .req      (req_i),
    .ptr      (ptr),
    .en       (arb_en),
    .grant    (arb_grant),
    .next_ptr (arb_ptr)
  );

  // While locked only the owner may proceed; everyone else waits even if it stalls.
  always_comb begin
    grant_o = arb_grant;
    if (state == ST_LOCK) begin
      grant_o = '0;
      if (has_credit && req_i[owner])
        grant_o[owner] = 1'b1;
    end
  end

  always_comb begin
    sel_flit = '0;
    win_idx  = '0;
    for (int k = 0; k < PORT_N; k++) begin
      if (grant_o[k]) begin
        sel_flit = flit_i[k*FW +: FW];
        win_idx  = PTR_W'(k);
      end
    end
  end

  assign granted  = |grant_o;
  assign sel_type = flit_type_t'(sel_flit[FW-1 -: 2]);
  assign busy_o   = (state == ST_LOCK);

  // Only a HEAD takes the lock; BODY/TAIL seen in IDLE pass through like HEADTAIL.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    case (state)
      ST_IDLE: begin
        if (granted) begin
          ptr_nxt = arb_ptr;
          if (sel_type == FT_HEAD) begin
            state_nxt = ST_LOCK;
            owner_nxt = win_idx;
          end
        end
      end
      ST_LOCK: begin
        if (granted && sel_type == FT_TAIL)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    credit_nxt = credit;
    if (granted && !credit_i)
      credit_nxt = credit - CNT_W'(1);
    else if (!granted && credit_i && !cred_full)
      credit_nxt = credit + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      owner      <= '0;
      credit     <= CNT_W'(BUF_DEPTH);
      flit_o     <= '0;
      valid_o    <= 1'b0;
      cred_err_o <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      owner   <= owner_nxt;
      credit  <= credit_nxt;
      valid_o <= granted;
      if (granted)
        flit_o <= sel_flit;
      if (credit_i && cred_full)
        cred_err_o <= 1'b1;
    end
  end

`ifdef OUTPUTC_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flit_cnt_o  <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (granted)
        flit_cnt_o <= flit_cnt_o + 32'd1;
      if ((req_i != '0) && !granted && !has_credit)
        stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_outputc_arb.sv
// Bench for outputc_arb: vector table, directed corner sequences and randomized traffic
// compared every cycle against a behavioural model of the output port.
module tb_outputc_arb;
  import noc_pkg::*;

  localparam int N     = 5;
  localparam int FWB   = FLIT_W;
  localparam int DEPTH = 4;
  localparam logic [2*N-1:0] ALL_HT = '1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_i = '0;
  logic [N*FWB-1:0] flit_i = '0;
  logic             credit_i = 1'b0;
  logic [N-1:0]     grant_o;
  logic [FWB-1:0]   flit_o;
  logic             valid_o, busy_o, cred_err_o;
`ifdef OUTPUTC_STATS_EN
  logic [31:0]      flit_cnt_o, stall_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  int             m_credit, m_ptr, m_owner;
  bit             m_lock, m_err;
  logic           m_vld;
  logic [FWB-1:0] m_flit;
  int unsigned    m_fcnt, m_scnt;

  always #5 clk = ~clk;

  outputc_arb dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .flit_i     (flit_i),
    .grant_o    (grant_o),
    .flit_o     (flit_o),
    .valid_o    (valid_o),
    .credit_i   (credit_i),
    .busy_o     (busy_o),
    .cred_err_o (cred_err_o)
`ifdef OUTPUTC_STATS_EN
    ,
    .flit_cnt_o (flit_cnt_o),
    .stall_cnt_o(stall_cnt_o)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_credit = DEPTH;
    m_ptr    = 0;
    m_owner  = 0;
    m_lock   = 0;
    m_err    = 0;
    m_vld    = 1'b0;
    m_flit   = '0;
    m_fcnt   = 0;
    m_scnt   = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    req_i    = '0;
    credit_i = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock of traffic: drive, compare DUT against the model, then advance the model.
  task automatic cycle(input logic [N-1:0] req, input logic [2*N-1:0] types, input logic cred,
                       output logic [N-1:0] g, output logic b);
    int             win;
    flit_t          f;
    logic [N*FWB-1:0] fv;
    logic [N-1:0]   eg;
    logic [1:0]     ft;
    fv = '0;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      f.ftype = flit_type_t'(types[2*k +: 2]);
      f.data  = $urandom;
      fv[k*FWB +: FWB] = f;
    end
    req_i    = req;
    flit_i   = fv;
    credit_i = cred;
    #1;
    win = -1;
    if (m_credit > 0) begin
      if (m_lock) begin
        if (req[m_owner]) win = m_owner;
      end else begin
        for (int k = 0; k < N; k++)
          if (win < 0 && req[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      end
    end
    eg = (win >= 0) ? N'(1 << win) : '0;
    check("grant", grant_o, eg);
    check("valid", valid_o, m_vld);
    if (m_vld) check("flit", flit_o, m_flit);
    check("busy", busy_o, m_lock);
    check("cred_err", cred_err_o, m_err);
`ifdef OUTPUTC_STATS_EN
    check("flit_cnt", flit_cnt_o, m_fcnt);
    check("stall_cnt", stall_cnt_o, m_scnt);
`endif
    g = grant_o;
    b = busy_o;
    @(posedge clk);
    if (win >= 0) begin
      ft = types[2*win +: 2];
      if (!m_lock) begin
        m_ptr = (win + 1) % N;
        if (ft == 2'b01) begin
          m_lock  = 1;
          m_owner = win;
        end
      end else if (ft == 2'b10) begin
        m_lock = 0;
      end
      m_vld  = 1'b1;
      m_flit = fv[win*FWB +: FWB];
      m_fcnt++;
    end else begin
      m_vld = 1'b0;
      if (req != '0 && m_credit == 0) m_scnt++;
    end
    if (cred && m_credit == DEPTH) m_err = 1;
    m_credit = m_credit - ((win >= 0) ? 1 : 0) + (cred ? 1 : 0);
    if (m_credit > DEPTH) m_credit = DEPTH;
  endtask

  typedef struct {
    bit             rst_before;
    logic [N-1:0]   req;
    logic [2*N-1:0] types;
    logic           cred;
    logic [N-1:0]   exp_grant;
    logic           exp_busy;
  } vec_t;

  initial begin
    vec_t         tbl[10];
    logic [N-1:0] g;
    logic         b;
    int           n;

    // Round-robin over inputs 0,2,4 with HEADTAIL flits
    tbl[0] = '{1'b1, 5'b10101, ALL_HT, 1'b0, 5'b00001, 1'b0};
    tbl[1] = '{1'b0, 5'b10101, ALL_HT, 1'b1, 5'b00100, 1'b0};
    tbl[2] = '{1'b0, 5'b10101, ALL_HT, 1'b1, 5'b10000, 1'b0};
    tbl[3] = '{1'b0, 5'b10101, ALL_HT, 1'b1, 5'b00001, 1'b0};
    tbl[4] = '{1'b0, 5'b10101, ALL_HT, 1'b1, 5'b00100, 1'b0};
    // Wormhole: input 1 HEAD, owner stall, BODY, TAIL; input 3 waits throughout
    tbl[5] = '{1'b1, 5'b01010, 10'b00_11_00_01_00, 1'b0, 5'b00010, 1'b0};
    tbl[6] = '{1'b0, 5'b01000, 10'b00_11_00_01_00, 1'b0, 5'b00000, 1'b1};
    tbl[7] = '{1'b0, 5'b01010, 10'b00_11_00_00_00, 1'b0, 5'b00010, 1'b1};
    tbl[8] = '{1'b0, 5'b01010, 10'b00_11_00_10_00, 1'b0, 5'b00010, 1'b1};
    tbl[9] = '{1'b0, 5'b01000, 10'b00_11_00_00_00, 1'b0, 5'b01000, 1'b0};

    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_grant", grant_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_cred_err", cred_err_o, 0);
    check("rst_flit", flit_o, 0);

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].rst_before) do_reset();
      cycle(tbl[i].req, tbl[i].types, tbl[i].cred, g, b);
      check($sformatf("tbl%0d_grant", i), g, tbl[i].exp_grant);
      check($sformatf("tbl%0d_busy", i), b, tbl[i].exp_busy);
    end

    // Credit exhaustion: 4 of 5 leave, 5th waits for a credit pulse
    do_reset();
    n = 0;
    repeat (5) begin
      cycle(5'b00001, ALL_HT, 1'b0, g, b);
      n += (g != 0) ? 1 : 0;
    end
    check("hold_grants", n, 4);
    cycle(5'b00001, ALL_HT, 1'b1, g, b);
    check("pulse_cycle_grant", g, 0);
    cycle(5'b00001, ALL_HT, 1'b0, g, b);
    check("after_pulse_grant", g, 5'b00001);
    cycle(5'b00000, ALL_HT, 1'b0, g, b);

    // Grant and credit together at counter 2 leaves it at 2
    do_reset();
    repeat (2) cycle(5'b00001, ALL_HT, 1'b0, g, b);
    cycle(5'b00001, ALL_HT, 1'b1, g, b);
    check("simul_grant", g, 5'b00001);
    n = 0;
    repeat (3) begin
      cycle(5'b00001, ALL_HT, 1'b0, g, b);
      n += (g != 0) ? 1 : 0;
    end
    check("simul_remaining", n, 2);

    // Credit return while full saturates and flags an error
    do_reset();
    cycle(5'b00000, ALL_HT, 1'b1, g, b);
    #1;
    check("cred_err_set", cred_err_o, 1);
    n = 0;
    repeat (5) begin
      cycle(5'b00001, ALL_HT, 1'b0, g, b);
      n += (g != 0) ? 1 : 0;
    end
    check("sat_grants", n, 4);

    // Reset in the middle of a locked packet
    do_reset();
    cycle(5'b00100, 10'b00_00_01_00_00, 1'b0, g, b);
    cycle(5'b00100, 10'b00_00_00_00_00, 1'b0, g, b);
    @(negedge clk);
    rst      = 1'b1;
    req_i    = '0;
    credit_i = 1'b0;
    #1;
    check("midrst_busy", busy_o, 0);
    check("midrst_valid", valid_o, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle(5'b00001, ALL_HT, 1'b0, g, b);
    check("post_rst_grant", g, 5'b00001);
    n = 1;
    repeat (4) begin
      cycle(5'b00001, ALL_HT, 1'b0, g, b);
      n += (g != 0) ? 1 : 0;
    end
    check("post_rst_credits", n, 4);

    // 10 flits with exactly 3 zero-credit stall cycles
    do_reset();
    repeat (4) cycle(5'b00001, ALL_HT, 1'b0, g, b);
    repeat (3) cycle(5'b00001, ALL_HT, 1'b0, g, b);
    repeat (4) cycle(5'b00000, ALL_HT, 1'b1, g, b);
    repeat (4) cycle(5'b00001, ALL_HT, 1'b0, g, b);
    repeat (2) cycle(5'b00000, ALL_HT, 1'b1, g, b);
    repeat (2) cycle(5'b00001, ALL_HT, 1'b0, g, b);
    cycle(5'b00000, ALL_HT, 1'b0, g, b);
`ifdef OUTPUTC_STATS_EN
    #1;
    check("stats_flits", flit_cnt_o, 10);
    check("stats_stalls", stall_cnt_o, 3);
`endif

    // Randomized traffic with occasional resets
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic [N-1:0]   r;
      logic [2*N-1:0] t;
      logic           c;
      if ($urandom_range(0, 199) == 0) do_reset();
      r = N'($urandom_range(0, 31));
      t = (2*N)'($urandom);
      c = ($urandom_range(0, 1) == 0);
      cycle(r, t, c, g, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
